mem_slot_arbiter: RTL and testbench

MEM_SLOT_ARBITER -- requirements
Module: mem_slot_arbiter

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 36 +++
 rtl/mem_slot_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_slot_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the memory slot arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational priority selector: first requester at or after ptr, wrapping to 0.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NCH = 3,
  parameter int IW  = idx_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  idx,
  output logic           any
);

  // Upper pass covers [ptr, NCH-1]; the lower pass only matters when it found nothing.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (!any && req[c] && (c >= int'(ptr))) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/mem_slot_arbiter.sv
// Shares one memory port between NCH requesters, one access per ce slot,
// with a MEM_LAT-deep tag pipeline routing read data back to its channel.
module mem_slot_arbiter
  import mem_arb_pkg::*;
#(
  parameter int        NCH     = 3,
  parameter int        AW      = 22,
  parameter int        DW      = 8,
  parameter int        MEM_LAT = 1,
  parameter arb_mode_t MODE    = ARB_RR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wdata,
  output logic [NCH-1:0]    ack,
  output logic [NCH-1:0]    rvalid,
  output logic [NCH*DW-1:0] rdata,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DW-1:0]     mem_dout,
  input  logic [DW-1:0]     mem_din
);

  localparam int IW = idx_w(NCH);

  logic [IW-1:0]              ptr_q, ptr_d, pick_ptr, pick_idx;
  logic [NCH-1:0]             gnt;
  logic                       any;
  logic [AW-1:0]              sel_addr;
  logic [DW-1:0]              sel_wdata;
  logic                       sel_we;

  logic [NCH-1:0]             ack_q, ack_d, rvalid_q, rvalid_d;
  logic [NCH*DW-1:0]          rdata_q, rdata_d;
  logic [AW-1:0]              mem_addr_q, mem_addr_d;
  logic [DW-1:0]              mem_dout_q, mem_dout_d;
  logic                       mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [MEM_LAT-1:0]         pipe_vld_q, pipe_vld_d;
  logic [MEM_LAT-1:0][IW-1:0] pipe_ch_q, pipe_ch_d;

  assign pick_ptr = (MODE == ARB_RR) ? ptr_q : '0;

  rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
    .req (req),
    .ptr (pick_ptr),
    .gnt (gnt),
    .idx (pick_idx),
    .any (any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (gnt[c]) begin
        sel_addr  = addr[c*AW +: AW];
        sel_wdata = wdata[c*DW +: DW];
        sel_we    = we[c];
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    ack_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_dout_d  = mem_dout_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    pipe_vld_d  = pipe_vld_q;
    pipe_ch_d   = pipe_ch_q;
    if (ce) begin
      mem_read_d  = any & ~sel_we;
      mem_write_d = any & sel_we;
      if (any) begin
        ack_d      = gnt;
        mem_addr_d = sel_addr;
        mem_dout_d = sel_wdata;
        ptr_d      = (int'(pick_idx) == NCH - 1) ? '0 : pick_idx + 1'b1;
      end
      // The tag leaving the last stage marks the slot where mem_din belongs to it.
      for (int c = 0; c < NCH; c++) begin
        if (pipe_vld_q[MEM_LAT-1] && (pipe_ch_q[MEM_LAT-1] == IW'(c))) begin
          rvalid_d[c]          = 1'b1;
          rdata_d[c*DW +: DW]  = mem_din;
        end
      end
      for (int s = 1; s < MEM_LAT; s++) begin
        pipe_vld_d[s] = pipe_vld_q[s-1];
        pipe_ch_d[s]  = pipe_ch_q[s-1];
      end
      pipe_vld_d[0] = any & ~sel_we;
      pipe_ch_d[0]  = pick_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= '0;
      ack_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_dout_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_ch_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      ack_q       <= ack_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_dout_q  <= mem_dout_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_ch_q   <= pipe_ch_d;
    end
  end

  assign ack       = ack_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_dout  = mem_dout_q;

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Directed bench: round-robin arbiter with MEM_LAT=2 and fixed-priority arbiter with MEM_LAT=3.
module tb_mem_slot_arbiter;
  import mem_arb_pkg::*;

  localparam int NCH = 3;
  localparam int AW  = 22;
  localparam int DW  = 8;

  logic clk, reset, ce;

  logic [NCH-1:0]    req_a, we_a, ack_a, rvalid_a;
  logic [NCH*AW-1:0] addr_a;
  logic [NCH*DW-1:0] wdata_a, rdata_a;
  logic [AW-1:0]     mem_addr_a;
  logic              mem_read_a, mem_write_a;
  logic [DW-1:0]     mem_dout_a, mem_din_a;

  logic [NCH-1:0]    req_b, we_b, ack_b, rvalid_b;
  logic [NCH*AW-1:0] addr_b;
  logic [NCH*DW-1:0] wdata_b, rdata_b;
  logic [AW-1:0]     mem_addr_b;
  logic              mem_read_b, mem_write_b;
  logic [DW-1:0]     mem_dout_b, mem_din_b;

  logic [DW-1:0] dly_a, dly_b1, dly_b2;
  int check_count, error_count;
  int g;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    case (a)
      22'h00010: return 8'hA5;
      22'h3FFFF: return 8'h5A;
      default:   return a[7:0] ^ 8'hC3;
    endcase
  endfunction

  // Memory models: read data appears MEM_LAT ce slots after the address is issued.
  always @(posedge clk) begin
    if (ce) begin
      dly_a  <= data_of(mem_addr_a);
      dly_b1 <= data_of(mem_addr_b);
      dly_b2 <= dly_b1;
    end
  end
  assign mem_din_a = dly_a;
  assign mem_din_b = dly_b2;

  mem_slot_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .MEM_LAT(2), .MODE(ARB_RR)) dut_a (
    .clk(clk), .reset(reset), .ce(ce), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .ack(ack_a), .rvalid(rvalid_a), .rdata(rdata_a),
    .mem_addr(mem_addr_a), .mem_read(mem_read_a), .mem_write(mem_write_a),
    .mem_dout(mem_dout_a), .mem_din(mem_din_a)
  );

  mem_slot_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .MEM_LAT(3), .MODE(ARB_FIXED)) dut_b (
    .clk(clk), .reset(reset), .ce(ce), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .ack(ack_b), .rvalid(rvalid_b), .rdata(rdata_b),
    .mem_addr(mem_addr_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
    .mem_dout(mem_dout_b), .mem_din(mem_din_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic ce_v, input logic [NCH-1:0] ra, input logic [NCH-1:0] rb);
    ce    = ce_v;
    req_a = ra;
    req_b = rb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    reset   = 1'b1;
    ce      = 1'b0;
    req_a   = '0;
    we_a    = '0;
    req_b   = '0;
    we_b    = '0;
    addr_a  = {22'h3FFFF, 22'h00200, 22'h00010};
    wdata_a = {8'h00, 8'h3C, 8'h00};
    addr_b  = {22'h00077, 22'h00055, 22'h00033};
    wdata_b = '0;
    #2 reset = 1'b0;

    $display("[TB] reset state");
    applyStimulus(1'b1, 3'b111, 3'b111);
    checkOutput("rst_ack_a", ack_a, 0);
    checkOutput("rst_rvalid_a", rvalid_a, 0);
    checkOutput("rst_rdata_a", rdata_a, 0);
    checkOutput("rst_mem_addr_a", mem_addr_a, 0);
    checkOutput("rst_mem_read_a", mem_read_a, 0);
    checkOutput("rst_mem_write_a", mem_write_a, 0);
    checkOutput("rst_mem_dout_a", mem_dout_a, 0);
    checkOutput("rst_ack_b", ack_b, 0);
    reset = 1'b1;

    $display("[TB] round-robin with ce every third clock");
    g = 0;
    for (int n = 0; n < 18; n++) begin
      applyStimulus((n % 3) == 0, 3'b111, 3'b000);
      checkOutput("rr_ack", ack_a, ce ? (64'd1 << g) : 64'd0);
      if (ce) begin
        checkOutput("rr_mem_read", mem_read_a, 1);
        g = (g + 1) % 3;
      end
    end
    for (int n = 0; n < 4; n++) applyStimulus(1'b1, 3'b000, 3'b000);

    $display("[TB] back-to-back reads ch0 then ch2");
    applyStimulus(1'b1, 3'b101, 3'b000);
    checkOutput("rd_ack0", ack_a, 3'b001);
    checkOutput("rd_addr0", mem_addr_a, 22'h00010);
    checkOutput("rd_read0", mem_read_a, 1);
    applyStimulus(1'b1, 3'b100, 3'b000);
    checkOutput("rd_ack2", ack_a, 3'b100);
    checkOutput("rd_addr2", mem_addr_a, 22'h3FFFF);
    checkOutput("rd_rvalid_early", rvalid_a, 0);
    applyStimulus(1'b1, 3'b000, 3'b000);
    checkOutput("rd_idle_read", mem_read_a, 0);
    checkOutput("rd_rvalid0", rvalid_a, 3'b001);
    checkOutput("rd_rdata0", rdata_a[0 +: DW], 8'hA5);
    applyStimulus(1'b1, 3'b000, 3'b000);
    checkOutput("rd_rvalid2", rvalid_a, 3'b100);
    checkOutput("rd_rdata2", rdata_a[2*DW +: DW], 8'h5A);
    checkOutput("rd_rdata0_hold", rdata_a[0 +: DW], 8'hA5);
    checkOutput("rd_rdata1_hold", rdata_a[DW +: DW], 8'hC3);
    applyStimulus(1'b1, 3'b000, 3'b000);
    checkOutput("rd_rvalid_done", rvalid_a, 0);

    $display("[TB] ch1 write");
    addr_a[AW +: AW] = 22'h00100;
    we_a = 3'b010;
    applyStimulus(1'b1, 3'b010, 3'b000);
    checkOutput("wr_ack", ack_a, 3'b010);
    checkOutput("wr_write", mem_write_a, 1);
    checkOutput("wr_read", mem_read_a, 0);
    checkOutput("wr_addr", mem_addr_a, 22'h00100);
    checkOutput("wr_dout", mem_dout_a, 8'h3C);
    we_a = 3'b000;
    applyStimulus(1'b1, 3'b000, 3'b000);
    checkOutput("wr_write_off", mem_write_a, 0);
    checkOutput("wr_dout_hold", mem_dout_a, 8'h3C);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b1, 3'b000, 3'b000);
      checkOutput("wr_no_rvalid", rvalid_a, 0);
    end
    checkOutput("wr_rdata1", rdata_a[DW +: DW], 8'hC3);

    $display("[TB] fixed priority with req 110");
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b1, 3'b000, 3'b110);
      checkOutput("fx_ack", ack_b, 3'b010);
      if (n >= 3) checkOutput("fx_rvalid", rvalid_b, 3'b010);
      if (n == 3) checkOutput("fx_rdata1", rdata_b[DW +: DW], 8'h96);
    end

    $display("[TB] reset with reads in flight");
    applyStimulus(1'b1, 3'b010, 3'b110);
    checkOutput("pr_ack1", ack_a, 3'b010);
    applyStimulus(1'b1, 3'b001, 3'b110);
    checkOutput("pr_ack0", ack_a, 3'b001);
    req_a = '0;
    req_b = '0;
    reset = 1'b0;
    #1;
    checkOutput("ar_ack_a", ack_a, 0);
    checkOutput("ar_mem_read_a", mem_read_a, 0);
    checkOutput("ar_mem_addr_a", mem_addr_a, 0);
    checkOutput("ar_rdata_a", rdata_a, 0);
    checkOutput("ar_ack_b", ack_b, 0);
    checkOutput("ar_mem_read_b", mem_read_b, 0);
    checkOutput("ar_mem_write_b", mem_write_b, 0);
    checkOutput("ar_mem_addr_b", mem_addr_b, 0);
    checkOutput("ar_mem_dout_b", mem_dout_b, 0);
    checkOutput("ar_rdata_b", rdata_b, 0);
    checkOutput("ar_rvalid_b", rvalid_b, 0);
    applyStimulus(1'b1, 3'b000, 3'b000);
    applyStimulus(1'b1, 3'b000, 3'b000);
    reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      applyStimulus(1'b1, 3'b000, 3'b000);
      checkOutput("post_rvalid_a", rvalid_a, 0);
      checkOutput("post_rvalid_b", rvalid_b, 0);
    end
    applyStimulus(1'b1, 3'b111, 3'b000);
    checkOutput("post_ack_ptr0", ack_a, 3'b001);
    checkOutput("post_mem_addr", mem_addr_a, 22'h00010);
    applyStimulus(1'b1, 3'b000, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
